// File: rtl/cpu_step_gen.sv
// cpu_step_gen: gates the CPU clock-enable stream for key-driven debugging.
// A debounced front-panel key releases one step (SINGLE) or a burst of
// steps (BURST). RUN passes ce_in through, HOLD blocks it.
module cpu_step_gen #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DEBOUNCE_W      = 18,
  parameter int BURST_W         = 8,
  parameter int COUNT_W         = 16
) (
  input  logic               clk24,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               n_key,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               ce_in,
  output logic               ce_out,
  output logic               busy,
  output logic [BURST_W-1:0] remaining,
  output logic [COUNT_W-1:0] step_count,
  output logic               key_level
);

  localparam logic [1:0] M_RUN    = 2'b00;
  localparam logic [1:0] M_SINGLE = 2'b01;
  localparam logic [1:0] M_BURST  = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_BURSTING = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Key path
  // ---------------------------------------------------------------------
  logic                  sync1_q, sync2_q;
  logic                  key_sync;
  logic [DEBOUNCE_W-1:0] dbc_q, dbc_d;
  logic                  key_level_q, key_level_d;
  logic                  key_prev_q;
  logic                  press;

  // Two-flop synchroniser; idles at 1 so reset looks like a released key.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= n_key;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = ~sync2_q;

  // Debounce: level must differ from the accepted level for the full window.
  always_comb begin
    dbc_d       = dbc_q;
    key_level_d = key_level_q;
    if (key_sync == key_level_q) begin
      dbc_d = '0;
    end else if (dbc_q == DB_LAST) begin
      key_level_d = key_sync;
      dbc_d       = '0;
    end else begin
      dbc_d = dbc_q + DEBOUNCE_W'(1);
    end
  end

  // Debounce counter and accepted level registers.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      dbc_q       <= '0;
      key_level_q <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      dbc_q       <= dbc_d;
      key_level_q <= key_level_d;
      key_prev_q  <= key_level_q;
    end
  end

  // Press is high in the first cycle the accepted level reads 1.
  assign press = key_level_q & ~key_prev_q;

  // ---------------------------------------------------------------------
  // Step state machine
  // ---------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [BURST_W-1:0]   rem_q, rem_d;
  logic [1:0]           mode_q;
  logic                 mode_chg;
  logic                 grant;
  logic                 ce_out_q, ce_out_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  assign mode_chg = (mode != mode_q);

  // Next state, remaining-count update and step grant.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    grant   = 1'b0;
    if (mode_chg) begin
      // A mode switch abandons any pending step, even a coincident ce_in.
      state_d = S_IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (press) begin
            if (mode == M_SINGLE) begin
              state_d = S_ARMED;
            end else if (mode == M_BURST && burst_len != '0) begin
              state_d = S_BURSTING;
              rem_d   = burst_len;
            end
          end
        end
        S_ARMED: begin
          if (ce_in) begin
            grant   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BURSTING: begin
          if (ce_in) begin
            grant = 1'b1;
            rem_d = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Output enable selection and step counter update.
  always_comb begin
    ce_out_d = 1'b0;
    cnt_d    = cnt_q;
    unique case (mode)
      M_RUN:    ce_out_d = ce_in;
      M_HOLD:   ce_out_d = 1'b0;
      M_SINGLE,
      M_BURST: begin
        ce_out_d = grant;
        if (grant) cnt_d = cnt_q + COUNT_W'(1);
      end
      default:  ce_out_d = 1'b0;
    endcase
  end

  // State, counters and the registered clock enable.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      mode_q   <= M_RUN;
      ce_out_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      mode_q   <= mode;
      ce_out_q <= ce_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ce_out     = ce_out_q;
  assign busy       = (state_q != S_IDLE);
  assign remaining  = rem_q;
  assign step_count = cnt_q;
  assign key_level  = key_level_q;

endmodule

// File: tb/tb_cpu_step_gen.sv
// Directed bench for cpu_step_gen with a short debounce window and a
// 4-bit step counter so wrap-around is reachable.
module tb_cpu_step_gen;
  localparam int DC = 4;
  localparam int DW = 3;
  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk24 = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          n_key;
  logic [BW-1:0] burst_len;
  logic          ce_in;
  logic          ce_out;
  logic          busy;
  logic [BW-1:0] remaining;
  logic [CW-1:0] step_count;
  logic          key_level;

  int checks = 0;
  int errors = 0;
  int cyc, ce_per, npulse, first_p;
  bit run_chk;

  cpu_step_gen #(
    .DEBOUNCE_CYCLES(DC), .DEBOUNCE_W(DW), .BURST_W(BW), .COUNT_W(CW)
  ) dut (
    .clk24(clk24), .reset(reset), .mode(mode), .n_key(n_key),
    .burst_len(burst_len), .ce_in(ce_in), .ce_out(ce_out), .busy(busy),
    .remaining(remaining), .step_count(step_count), .key_level(key_level)
  );

  always #5 clk24 = ~clk24;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive ce_in from the pulse pattern, sample 1 after the edge.
  task automatic step();
    bit ce;
    ce = (ce_per != 0) && (cyc % ce_per == 0);
    ce_in = ce;
    @(posedge clk24); #1;
    if (ce_out) begin
      npulse++;
      if (first_p < 0) first_p = cyc;
    end
    if (run_chk) chk("run_ce", int'(ce_out), int'(ce));
    cyc++;
  endtask

  // Move the key and wait (bounded) for the debounced level to follow.
  task automatic set_key(input bit pressed);
    int lat = 0;
    n_key = !pressed;
    while (key_level != pressed && lat < 20) begin
      step();
      lat++;
    end
    chk("key_lat", lat, 2 + DC);
  endtask

  initial begin
    int bad;
    reset = 1'b1; n_key = 1'b1; mode = 2'b00; ce_in = 1'b0; burst_len = '0;
    cyc = 0; ce_per = 0; npulse = 0; first_p = -1; run_chk = 1'b0;
    #12;
    chk("rst_ce_out", int'(ce_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_step_count", int'(step_count), 0);
    chk("rst_key_level", int'(key_level), 0);
    @(posedge clk24); #1;
    reset = 1'b0;

    // SINGLE: one press, ce_in every 4 cycles
    mode = 2'b01; step();
    set_key(1'b1);
    npulse = 0; first_p = -1; ce_per = 4; cyc = 0;
    step();
    chk("single_busy", int'(busy), 1);
    repeat (39) step();
    chk("single_pulses", npulse, 1);
    chk("single_first", first_p, 4);
    chk("single_count", int'(step_count), 1);
    chk("single_idle", int'(busy), 0);

    // BURST of 5 with a second press mid-burst
    ce_per = 0; set_key(1'b0);
    mode = 2'b10; burst_len = 8'd5;
    set_key(1'b1);
    step();
    chk("burst_rem_load", int'(remaining), 5);
    chk("burst_busy", int'(busy), 1);
    npulse = 0; ce_per = 4; cyc = 0;
    set_key(1'b0);
    chk("burst_rem_mid", int'(remaining), 3);
    set_key(1'b1);
    repeat (20) step();
    chk("burst_pulses", npulse, 5);
    chk("burst_rem_end", int'(remaining), 0);
    chk("burst_idle", int'(busy), 0);
    chk("burst_count", int'(step_count), 6);

    // BURST with zero length: press ignored
    ce_per = 0; set_key(1'b0);
    burst_len = 8'd0;
    set_key(1'b1);
    step();
    chk("len0_busy", int'(busy), 0);
    npulse = 0; ce_per = 4; cyc = 0;
    repeat (20) step();
    chk("len0_pulses", npulse, 0);
    chk("len0_idle", int'(busy), 0);
    ce_per = 0; set_key(1'b0);

    // RUN: pass-through delayed one cycle
    mode = 2'b00; step();
    ce_per = 3; cyc = 0; run_chk = 1'b1;
    repeat (20) step();
    run_chk = 1'b0;
    chk("run_count", int'(step_count), 6);

    // HOLD: nothing passes
    mode = 2'b11; npulse = 0; ce_per = 2; cyc = 0;
    repeat (20) step();
    chk("hold_pulses", npulse, 0);

    // Bounce: 3-cycle glitches never accepted
    ce_per = 0; mode = 2'b01; step();
    bad = 0;
    repeat (3) begin
      n_key = 1'b0;
      repeat (3) begin step(); if (key_level) bad++; end
      n_key = 1'b1;
      repeat (5) begin step(); if (key_level) bad++; end
    end
    chk("bounce_level", bad, 0);
    chk("bounce_busy", int'(busy), 0);

    // Mode change mid-burst, coincident with a ce_in
    mode = 2'b10; burst_len = 8'd5;
    set_key(1'b1);
    step();
    npulse = 0; ce_per = 4; cyc = 0;
    repeat (5) step();
    chk("chg_rem_before", int'(remaining), 3);
    repeat (3) step();
    mode = 2'b01;
    step();
    chk("chg_ce_out", int'(ce_out), 0);
    chk("chg_rem", int'(remaining), 0);
    chk("chg_busy", int'(busy), 0);
    repeat (20) step();
    chk("chg_pulses", npulse, 2);
    chk("chg_count", int'(step_count), 8);

    // Reset mid-burst clears everything asynchronously
    ce_per = 0; set_key(1'b0);
    mode = 2'b10; burst_len = 8'd5;
    set_key(1'b1);
    step();
    ce_per = 4; cyc = 0;
    repeat (3) step();
    chk("rstb_busy_pre", int'(busy), 1);
    #2;
    reset = 1'b1; n_key = 1'b1; ce_in = 1'b0;
    #1;
    chk("rstb_ce_out", int'(ce_out), 0);
    chk("rstb_busy", int'(busy), 0);
    chk("rstb_remaining", int'(remaining), 0);
    chk("rstb_step_count", int'(step_count), 0);
    chk("rstb_key_level", int'(key_level), 0);
    ce_per = 0;
    @(posedge clk24); #1;
    reset = 1'b0;
    repeat (4) step();

    // 17 single steps wrap the 4-bit counter to 1
    mode = 2'b01; step();
    npulse = 0;
    repeat (17) begin
      set_key(1'b1);
      ce_per = 4; cyc = 0;
      repeat (8) step();
      ce_per = 0;
      set_key(1'b0);
    end
    chk("wrap_pulses", npulse, 17);
    chk("wrap_count", int'(step_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_step_gen.md
# cpu_step_gen

Parametrised CPU step generator for key-driven debugging of the Vector-06C core. It debounces a front-panel step key. Depending on `mode`, it forwards the normal CPU clock-enable stream, blocks it, releases exactly one CPU clock per key press, or releases a programmable burst of clocks per key press. It sits between the clock-enable generator and the CPU clock-enable input, and provides status outputs for the on-screen debugger.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 240000: number of clk24 cycles the synchronised key level must hold before it is accepted (10 ms at 24 MHz); must be ≥ 1.
- `DEBOUNCE_W`, default 18: width of the debounce counter; must satisfy 2^DEBOUNCE_W > DEBOUNCE_CYCLES.
- `BURST_W`, default 8: width of the burst length and remaining-count fields.
- `COUNT_W`, default 16: width of the issued-step counter.

Ports:
- `clk24`, input, 1: the single system clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `mode`, input, 2: operating mode. 00 = RUN, 01 = SINGLE, 10 = BURST, 11 = HOLD.
- `n_key`, input, 1: raw step key, active low, asynchronous to clk24.
- `burst_len`, input, BURST_W: number of steps per press in BURST mode; sampled at the accepted press.
- `ce_in`, input, 1: CPU clock-enable pulses from the clock generator.
- `ce_out`, output, 1: gated clock enable to the CPU; registered.
- `busy`, output, 1: a step or burst is pending.
- `remaining`, output, BURST_W: steps still to issue in the current burst.
- `step_count`, output, COUNT_W: total number of `ce_out` pulses issued in SINGLE and BURST modes; wraps.
- `key_level`, output, 1: debounced key level, active high (1 = pressed).

## Operation
Key path:
- `n_key` passes through a 2-flop synchroniser, then is inverted to give `key_sync`.
- The debounce counter clears whenever `key_sync` equals `key_level`; otherwise it increments.
- When the counter reaches `DEBOUNCE_CYCLES - 1`, `key_level` takes the value of `key_sync` and the counter clears.
- A `press` event is a one-cycle internal pulse on a 0→1 transition of `key_level`. Releases generate no event.

State machine states: IDLE, ARMED, BURSTING.
- IDLE:
  - On `press` in SINGLE → ARMED.
  - On `press` in BURST with `burst_len` ≠ 0 → BURSTING, with `remaining` loaded from `burst_len`.
  - On `press` in BURST with `burst_len` = 0, the press is ignored.
  - On `press` in RUN or HOLD, the press is ignored.
- ARMED: on the first `ce_in` = 1 → IDLE; that cycle grants one step.
- BURSTING:
  - Each `ce_in` = 1 grants one step and decrements `remaining`.
  - When the granted step takes `remaining` from 1 to 0 → IDLE.
- `press` while in ARMED or BURSTING is ignored; there is no queueing.
- Any change of `mode` value forces IDLE and clears `remaining`, in the same cycle as the change. If `ce_in` coincides with that change, no step is granted.

Outputs:
- RUN: `ce_out` is `ce_in` delayed one cycle. `step_count` does not change.
- HOLD: `ce_out` is 0.
- SINGLE/BURST: `ce_out` is registered from the grant, i.e. it pulses one cycle after the granting `ce_in`. `step_count` increments on every granted step, wrapping from 2^COUNT_W−1 to 0.
- `busy` is 1 in ARMED or BURSTING.

Reset values:
- `ce_out` = 0, `busy` = 0, `remaining` = 0, `step_count` = 0, `key_level` = 0.
- Synchroniser flops = 1 (key released); debounce counter = 0; state = IDLE.
- A reset asserted mid-burst aborts the burst immediately.

## Timing
- Key latency: 2 synchroniser cycles + `DEBOUNCE_CYCLES` cycles of stable level until `key_level` changes. `press` is asserted in the cycle `key_level` becomes 1.
- `press` takes effect on the next edge, so the earliest granting `ce_in` is the cycle after `press`. `ce_out` follows 1 cycle after the grant.
- Exactly one `ce_out` pulse per granting `ce_in`. `ce_out` is never high for two consecutive cycles unless `ce_in` was.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no event.
- `burst_len` and `mode` are assumed quasi-static from the clk24 domain; no synchroniser is applied to them.

## Test plan
- Reset with `DEBOUNCE_CYCLES`=4: all outputs are 0. Hold `n_key`=0 for 10 cycles → `key_level`=1 exactly 6 cycles after the falling edge.
- SINGLE mode, one press, `ce_in` pulsing every 4 cycles for 40 cycles → exactly one `ce_out` pulse, 1 cycle after the first `ce_in` following `press`. `step_count`=1 and `busy` returns to 0.
- BURST mode, `burst_len`=5, one press, then a second press mid-burst → exactly 5 `ce_out` pulses; `remaining` counts 5→0; the second press is ignored; `step_count`=5.
- BURST mode with `burst_len`=0 and a press → no `ce_out` and `busy` stays 0. RUN mode → `ce_out` equals `ce_in` delayed 1 cycle and `step_count` is unchanged. HOLD mode → `ce_out` stays 0.
- Key bounce: 3-cycle low glitches with `DEBOUNCE_CYCLES`=4 → no `press`. Mode change from BURST to SINGLE at `remaining`=3 → state IDLE, `remaining`=0, no further pulses.
- `COUNT_W`=4: 17 single steps → `step_count` wraps to 1. Assert `reset` in mid-burst → all outputs are 0 asynchronously.
